// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, time type and range limits for the alarm responder
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } state_t;

    localparam logic [7:0] HR_LAST  = 8'd23;
    localparam logic [7:0] MIN_LAST = 8'd59;
    localparam logic [7:0] SEC_LAST = 8'd59;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
    } time_t;

    function automatic logic time_valid(input time_t t);
        return (t.hr <= HR_LAST) && (t.min <= MIN_LAST) && (t.sec <= SEC_LAST);
    endfunction

endpackage

// File: rtl/alarm_time_add_min.sv
// alarm_time_add_min: adds a fixed number of minutes to a time, wrapping minutes into hours and 23h into 0h
import alarm_pkg::*;

module alarm_time_add_min #(
    parameter int ADD_MIN = 5
) (
    input  time_t i_time,
    output time_t o_time
);

    logic [8:0] w_sum;

    // Both operands are at most 59, so a single subtraction of 60 always lands back in range
    always_comb begin
        w_sum  = {1'b0, i_time.min} + 9'(ADD_MIN);
        o_time = i_time;
        if (w_sum > {1'b0, MIN_LAST}) begin
            o_time.min = 8'(w_sum - 9'd60);
            o_time.hr  = (i_time.hr == HR_LAST) ? 8'd0 : i_time.hr + 8'd1;
        end else begin
            o_time.min = w_sum[7:0];
        end
    end

endmodule

// File: rtl/alarm_responder.sv
// alarm_responder: holds the alarm time, rings on a tick-aligned match and handles snooze, dismiss and timeout
import alarm_pkg::*;

module alarm_responder #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       tick_1s,
    input  logic [7:0] hr,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic       arm,
    input  logic       set_en,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic [7:0] alm_hr,
    output logic [7:0] alm_min,
    output logic [7:0] alm_sec,
    output logic       ringing,
    output logic       armed,
    output logic [1:0] snooze_cnt,
    output logic       set_err
);

    localparam int RCW = $clog2(RING_TIMEOUT_S + 1);

    state_t         r_state, w_state_nxt;
    time_t          r_alm, w_alm_nxt;
    time_t          r_wake, w_wake_nxt;
    time_t          w_now, w_set, w_snz;
    logic [RCW-1:0] r_ring_cnt, w_ring_cnt_nxt;
    logic [1:0]     r_snooze_cnt, w_snooze_cnt_nxt;
    logic           r_set_err, w_set_err_nxt;
    logic           w_match, w_timeout, w_can_snooze, w_set_ok;

    assign w_now        = {hr, min, sec};
    assign w_set        = {set_hr, set_min, set_sec};
    assign w_match      = tick_1s && (w_now == r_wake);
    assign w_timeout    = tick_1s && (r_ring_cnt == RCW'(RING_TIMEOUT_S - 1));
    assign w_can_snooze = r_snooze_cnt < 2'(MAX_SNOOZE);
    assign w_set_ok     = ((r_state == IDLE) || (r_state == ARMED)) && time_valid(w_set);

    alarm_time_add_min #(.ADD_MIN(SNOOZE_MIN)) u_snz (
        .i_time (r_wake),
        .o_time (w_snz)
    );

    // Next-state logic; arm=0 overrides everything, then dismiss, timeout, snooze and match in that order
    always_comb begin
        w_state_nxt      = r_state;
        w_alm_nxt        = r_alm;
        w_wake_nxt       = r_wake;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        w_set_err_nxt    = 1'b0;
        if (!arm) begin
            w_state_nxt      = IDLE;
            w_snooze_cnt_nxt = 2'd0;
            w_wake_nxt       = r_alm;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ARMED;
                ARMED: begin
                    if (w_match) begin
                        w_state_nxt    = RINGING;
                        w_ring_cnt_nxt = '0;
                    end
                end
                RINGING: begin
                    if (tick_1s) w_ring_cnt_nxt = r_ring_cnt + RCW'(1);
                    if (dismiss_btn || w_timeout) begin
                        w_state_nxt      = ARMED;
                        w_snooze_cnt_nxt = 2'd0;
                        w_wake_nxt       = r_alm;
                    end else if (snooze_btn && w_can_snooze) begin
                        w_state_nxt      = SNOOZED;
                        w_snooze_cnt_nxt = r_snooze_cnt + 2'd1;
                        w_wake_nxt       = w_snz;
                    end
                end
                SNOOZED: begin
                    if (dismiss_btn) begin
                        w_state_nxt      = ARMED;
                        w_snooze_cnt_nxt = 2'd0;
                        w_wake_nxt       = r_alm;
                    end else if (w_match) begin
                        w_state_nxt    = RINGING;
                        w_ring_cnt_nxt = '0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        if (set_en) begin
            if (w_set_ok) begin
                w_alm_nxt  = w_set;
                w_wake_nxt = w_set;
            end else begin
                w_set_err_nxt = 1'b1;
            end
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= IDLE;
            r_alm        <= '0;
            r_wake       <= '0;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= 2'd0;
            r_set_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_alm        <= w_alm_nxt;
            r_wake       <= w_wake_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_set_err    <= w_set_err_nxt;
        end
    end

    assign ringing    = (r_state == RINGING);
    assign armed      = (r_state != IDLE);
    assign snooze_cnt = r_snooze_cnt;
    assign set_err    = r_set_err;
    assign alm_hr     = r_alm.hr;
    assign alm_min    = r_alm.min;
    assign alm_sec    = r_alm.sec;

endmodule

// File: doc/alarm_responder.md
Name: alarm_responder

Overview:
- Responder side of the timekeeping core's alarm interface.
- Holds the programmed alarm time and compares it against the running hr/min/sec on each 1 s tick.
- Drives the ringing output and handles the user's snooze and dismiss requests, with a ring timeout and a snooze limit.
- Sits between the time counter and the buzzer/button front end. Buttons arrive already synchronized and as single-cycle pulses.

Parameters:
- SNOOZE_MIN, 5: minutes added to the wake target per snooze; legal range 1..59.
- RING_TIMEOUT_S, 60: number of tick_1s pulses after which ringing auto-dismisses; legal range ≥1.
- MAX_SNOOZE, 3: maximum snoozes per alarm event; legal range 1..3.

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- tick_1s  in  1  one-cycle pulse; hr/min/sec show the new time in this cycle
- hr  in  8  current hour, binary 0..23
- min  in  8  current minute, binary 0..59
- sec  in  8  current second, binary 0..59
- arm  in  1  level; 1 = alarm enabled
- set_en  in  1  one-cycle pulse; load set_hr/set_min/set_sec
- set_hr, set_min, set_sec  in  8 each  programmed alarm time
- snooze_btn  in  1  one-cycle pulse
- dismiss_btn  in  1  one-cycle pulse
- alm_hr, alm_min, alm_sec  out  8 each  programmed alarm time (registered)
- ringing  out  1  buzzer enable
- armed  out  1  1 while state is not IDLE
- snooze_cnt  out  2  snoozes used in the current event
- set_err  out  1  one-cycle pulse: set request rejected

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE.
  - Programmed time and wake target = 00:00:00.
  - ringing=0, armed=0, snooze_cnt=0, set_err=0, ring_cnt=0.
- States: IDLE, ARMED, RINGING, SNOOZED. All transitions are registered, so outputs change one cycle after the triggering input.
- Priority within one cycle:
  1. arm=0
  2. dismiss_btn
  3. timeout
  4. snooze_btn
  5. match
- arm=0 in any state:
  - next state IDLE, ringing=0, snooze_cnt=0, wake target reloaded from the programmed time.
  - IDLE→ARMED when arm=1.
- set_en:
  - Accepted only in IDLE or ARMED.
  - Fields must satisfy hr<24, min<60, sec<60. If valid, the programmed time and wake target both load.
  - If out of range, or if the state is RINGING or SNOOZED, registers are unchanged and set_err=1 for exactly one cycle.
- ARMED:
  - In a cycle with tick_1s=1 and {hr,min,sec}==wake target: go to RINGING, ring_cnt=0.
  - No match is checked in a cycle without tick_1s.
- RINGING:
  - ringing=1.
  - Each tick_1s increments ring_cnt.
  - dismiss_btn → ARMED; snooze_cnt=0; wake target=programmed time (rings again next day).
  - Timeout: tick_1s with ring_cnt==RING_TIMEOUT_S-1 is handled as a dismiss. Ringing therefore lasts exactly RING_TIMEOUT_S ticks.
  - snooze_btn with snooze_cnt<MAX_SNOOZE → SNOOZED; snooze_cnt+1; wake target += SNOOZE_MIN minutes.
  - snooze_btn with snooze_cnt==MAX_SNOOZE is ignored; ringing continues.
- SNOOZED:
  - ringing=0.
  - tick_1s match against the wake target → RINGING, ring_cnt=0.
  - dismiss_btn → ARMED with the same reset as a RINGING dismiss.
- Snooze arithmetic:
  - m = wake_min + SNOOZE_MIN.
  - If m≥60: m-=60 and hour+1, with hour 23→0.
  - Seconds are unchanged.
- Wake target never equals an illegal time.
- Mid-operation reset forces all state and outputs to their reset values immediately.

Decomposition:
- Package alarm_pkg:
  - state enum (IDLE, ARMED, RINGING, SNOOZED)
  - constants HR_LAST=23, MIN_LAST=59, SEC_LAST=59
  - time struct {hr,min,sec}
- Sub-module alarm_time_add_min: combinational add-minutes with minute and hour wrap, used for snooze.

Test Plan:
- Set 06:30:00, arm=1, drive time to 06:30:00 on tick_1s → ringing=1 in the next cycle; dismiss → ringing=0, wake target back to 06:30:00, snooze_cnt=0.
- Alarm 23:58:10, SNOOZE_MIN=5, snooze in RINGING → wake target 00:03:10; ringing reasserts when time reaches 00:03:10.
- Four snoozes with MAX_SNOOZE=3 → snooze_cnt saturates at 3; the 4th snooze_btn is ignored and ringing stays 1.
- RINGING with no buttons, RING_TIMEOUT_S=60 → ringing drops after the 60th tick_1s; state ARMED.
- set_en with set_min=60, and separately set_en during RINGING → set_err pulses one cycle each time; alm_* unchanged.
- Deassert arm during SNOOZED, and separately pulse clr_n low during RINGING → ringing=0 and snooze_cnt=0; after the clr_n pulse, alm_* = 00:00:00.
